vid_fetch_sched: RTL
====================

Name: vid_fetch_sched

Overview:
Pixel-fetch scheduler for the video controller. Each frame it walks the framebuffer line by line and issues burst read requests on the shared bus. It accepts the returned data phases and pushes one RGB pixel per beat into the pixel FIFO, never overfilling it. It sits between the register block (base address, line increment, sizes, enable), the bus arbiter, and the R/G/B pixel FIFOs.

Parameters:
FIFO_DEPTH, 16, pixel FIFO depth in entries.
LVL_W, 5, width of the FIFO occupancy input.
MAX_BURST, 4, longest burst in beats; lenout encoding is 00=1, 01=2, 10=4, 11 reserved and never driven.

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
en  in  1  controller enable (cr.en)
frame_start  in  1  one-cycle pulse at start of vertical sync
base_addr  in  32  framebuffer address of line 0
lineinc  in  32  byte stride between lines
hsize  in  13  displayed pixels per line
vsize  in  13  displayed lines per frame
fifo_level  in  LVL_W  current pixel FIFO occupancy
bus_gnt  in  1  arbiter grant
cmdin  in  3  bus command in; 3'b011 = read data beat
datain  in  32  bus data in; pixel is [23:16]=R, [15:8]=G, [7:0]=B
bus_req  out  1  request to arbiter
cmdout  out  3  bus command out; 3'b010 = read request, else 3'b000
lenout  out  2  burst length code
addrout  out  32  burst start address
fifo_wr  out  1  push strobe to R/G/B FIFOs
fifo_wdata  out  24  {R,G,B} pixel
frame_overrun  out  1  sticky: frame_start arrived before frame fetch completed

Behaviour:
- Reset, asynchronous on reset_n low: state=IDLE. bus_req, fifo_wr and frame_overrun are 0. cmdout=3'b000, lenout=2'b00, addrout=0, fifo_wdata=0. All counters are 0.
- States:
  - IDLE: leaves when en=1, goes to WAIT_FRAME.
  - WAIT_FRAME: on frame_start, latch base_addr, lineinc, hsize and vsize. Set line_addr=base_addr, pix=0, line=0, then go to CHECK. If the latched hsize=0 or vsize=0, stay in WAIT_FRAME.
  - CHECK: compute rem=hsize-pix. blen is 4 if rem>=4, else 2 if rem>=2, else 1.
    - If en=0, go to IDLE.
    - Else if fifo_level <= FIFO_DEPTH-blen, go to REQ.
    - Otherwise wait in CHECK.
  - REQ: bus_req=1 until bus_gnt is sampled high, then go to ADDR.
  - ADDR: exactly one cycle. Drive cmdout=3'b010, lenout=code(blen), addrout=line_addr+4*pix. bus_req=0. Set beat=0, go to DATA.
  - DATA: every cycle with cmdin=3'b011 is one beat; capture datain[23:0] and increment beat. Cycles with any other cmdin are wait states. After beat reaches blen, pix+=blen and go to NEXT.
  - NEXT:
    - If pix<hsize, go to CHECK.
    - Else set pix=0, line+=1, line_addr+=lineinc (32-bit wrap allowed).
    - If line<vsize, go to CHECK; else go to WAIT_FRAME.
- FIFO push: fifo_wr=1 and fifo_wdata=datain[23:0] are registered, appearing the cycle after each beat (1-cycle latency). Back-to-back beats give back-to-back pushes. Beats beyond blen are ignored.
- Space check: blen counts only pushes not yet reflected in fifo_level. The check is evaluated only in CHECK, after all prior pushes have landed, so the FIFO never overflows.
- en low:
  - In CHECK or WAIT_FRAME: go to IDLE next cycle.
  - In REQ/ADDR/DATA: the burst in progress completes, then the block goes to IDLE.
  - frame_overrun clears while en=0.
- frame_start outside WAIT_FRAME/IDLE: set frame_overrun=1 and latch a restart. After the current burst's NEXT, the block reloads the registers and restarts at line 0 instead of continuing.
- Arithmetic: pix and line are 13-bit, beat is 3-bit. The 4*pix offset is zero-extended to 32 bits.

Test Plan:
1. hsize=8, vsize=2, base=0x1000, lineinc=0x100, fifo_level=0, gnt 1 cycle after req -> reads at 0x1000, 0x1010, 0x1100, 0x1110, each lenout=10. 16 pushes with data matching datain[23:0], 1-cycle latency. Ends in WAIT_FRAME.
2. hsize=7 -> per line, bursts of len codes 10, 01, 00 at offsets 0, 16, 24. Exactly 7 pushes per line.
3. fifo_level=13 with blen=4 -> stays in CHECK, bus_req=0. Drop level to 12 -> bus_req next cycle.
4. Insert 2 idle cycles (cmdin=000) between beats -> no push during gaps; total pushes still 4.
5. frame_start mid-frame (line 1 of 4) -> frame_overrun=1; next request addr=base_addr. en=0 then clears the flag.
6. reset_n low during DATA -> all outputs immediately at reset values. After release with en=1, waits for frame_start.

Source files
------------

// File: rtl/vid_fetch_sched.sv
// Pixel-fetch scheduler: walks the framebuffer line by line, issues burst reads
// on the shared bus and pushes one {R,G,B} pixel per returned beat into the FIFO.
module vid_fetch_sched #(
  parameter int FIFO_DEPTH = 16,
  parameter int LVL_W      = 5,
  parameter int MAX_BURST  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             frame_start,
  input  logic [31:0]      base_addr,
  input  logic [31:0]      lineinc,
  input  logic [12:0]      hsize,
  input  logic [12:0]      vsize,
  input  logic [LVL_W-1:0] fifo_level,
  input  logic             bus_gnt,
  input  logic [2:0]       cmdin,
  input  logic [31:0]      datain,
  output logic             bus_req,
  output logic [2:0]       cmdout,
  output logic [1:0]       lenout,
  output logic [31:0]      addrout,
  output logic             fifo_wr,
  output logic [23:0]      fifo_wdata,
  output logic             frame_overrun
);

  localparam logic [2:0] CMD_IDLE    = 3'b000;
  localparam logic [2:0] CMD_RD_REQ  = 3'b010;
  localparam logic [2:0] CMD_RD_DATA = 3'b011;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_FRAME,
    S_CHECK,
    S_REQ,
    S_ADDR,
    S_DATA,
    S_NEXT
  } state_e;

  state_e      state_q;
  logic [31:0] lineinc_q;
  logic [31:0] line_addr_q;
  logic [12:0] hsize_q;
  logic [12:0] vsize_q;
  logic [12:0] pix_q;
  logic [12:0] line_q;
  logic [2:0]  beat_q;
  logic [2:0]  blen_q;
  logic        restart_q;

  logic        bus_req_q;
  logic [2:0]  cmd_q;
  logic [1:0]  len_q;
  logic [31:0] addr_q;
  logic        wr_q;
  logic [23:0] wdata_q;
  logic        overrun_q;

  logic [12:0] rem_d;
  logic [2:0]  blen_d;
  logic        space_ok_d;
  logic        overrun_hit_d;
  logic        load_frame_d;
  logic        frame_ok_d;
  logic        unused_hi;

  // The top data byte carries no pixel information.
  assign unused_hi = ^datain[31:24];

  function automatic logic [1:0] len_code(input logic [2:0] blen);
    case (blen)
      3'd4:    len_code = 2'b10;
      3'd2:    len_code = 2'b01;
      default: len_code = 2'b00;
    endcase
  endfunction

  always_comb begin
    rem_d = hsize_q - pix_q;
    if (rem_d >= 13'(MAX_BURST)) begin
      blen_d = 3'(MAX_BURST);
    end else if (rem_d >= 13'd2) begin
      blen_d = 3'd2;
    end else begin
      blen_d = 3'd1;
    end
    // All earlier pushes have landed by the time CHECK runs, so only this burst is unaccounted for.
    space_ok_d    = (32'(fifo_level) + 32'(blen_d)) <= 32'(FIFO_DEPTH);
    overrun_hit_d = en && frame_start && (state_q != S_IDLE) && (state_q != S_WAIT_FRAME);
    frame_ok_d    = (hsize != 13'd0) && (vsize != 13'd0);
    load_frame_d  = en && (((state_q == S_WAIT_FRAME) && frame_start) ||
                           ((state_q == S_NEXT) && (restart_q || frame_start)));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every branch below
  // sees the values from before the clock edge regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      lineinc_q   <= '0;
      line_addr_q <= '0;
      hsize_q     <= '0;
      vsize_q     <= '0;
      pix_q       <= '0;
      line_q      <= '0;
      beat_q      <= '0;
      blen_q      <= '0;
      restart_q   <= 1'b0;
      bus_req_q   <= 1'b0;
      cmd_q       <= CMD_IDLE;
      len_q       <= 2'b00;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      overrun_q   <= 1'b0;
    end else begin
      wr_q <= 1'b0;

      if (!en) begin
        overrun_q <= 1'b0;
      end else if (overrun_hit_d) begin
        overrun_q <= 1'b1;
        restart_q <= 1'b1;
      end

      if (load_frame_d) begin
        lineinc_q   <= lineinc;
        hsize_q     <= hsize;
        vsize_q     <= vsize;
        line_addr_q <= base_addr;
        pix_q       <= '0;
        line_q      <= '0;
      end

      unique case (state_q)
        S_IDLE: begin
          restart_q <= 1'b0;
          if (en) state_q <= S_WAIT_FRAME;
        end
        S_WAIT_FRAME: begin
          if (!en) state_q <= S_IDLE;
          else if (load_frame_d && frame_ok_d) state_q <= S_CHECK;
        end
        S_CHECK: begin
          if (!en) begin
            state_q <= S_IDLE;
          end else if (space_ok_d) begin
            blen_q    <= blen_d;
            bus_req_q <= 1'b1;
            state_q   <= S_REQ;
          end
        end
        S_REQ: begin
          if (bus_gnt) begin
            bus_req_q <= 1'b0;
            cmd_q     <= CMD_RD_REQ;
            len_q     <= len_code(blen_q);
            addr_q    <= line_addr_q + {17'b0, pix_q, 2'b00};
            beat_q    <= '0;
            state_q   <= S_ADDR;
          end
        end
        S_ADDR: begin
          cmd_q   <= CMD_IDLE;
          state_q <= S_DATA;
        end
        S_DATA: begin
          if (cmdin == CMD_RD_DATA) begin
            wr_q    <= 1'b1;
            wdata_q <= datain[23:0];
            beat_q  <= beat_q + 3'd1;
            if (beat_q + 3'd1 == blen_q) begin
              pix_q   <= pix_q + 13'(blen_q);
              state_q <= S_NEXT;
            end
          end
        end
        S_NEXT: begin
          restart_q <= 1'b0;
          if (!en) begin
            state_q <= S_IDLE;
          end else if (load_frame_d) begin
            state_q <= frame_ok_d ? S_CHECK : S_WAIT_FRAME;
          end else if (pix_q < hsize_q) begin
            state_q <= S_CHECK;
          end else begin
            pix_q       <= '0;
            line_q      <= line_q + 13'd1;
            line_addr_q <= line_addr_q + lineinc_q;
            state_q     <= (line_q + 13'd1 < vsize_q) ? S_CHECK : S_WAIT_FRAME;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus_req       = bus_req_q;
  assign cmdout        = cmd_q;
  assign lenout        = len_q;
  assign addrout       = addr_q;
  assign fifo_wr       = wr_q;
  assign fifo_wdata    = wdata_q;
  assign frame_overrun = overrun_q;

endmodule
